// File: rtl/tcdm2axi_pkg.sv
// Shared types and AXI constants for the TCDM-to-AXI4 single-beat bridge.
package tcdm2axi_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned CACHE_W  = 4;
  localparam int unsigned PROT_W   = 3;
  localparam int unsigned QOS_W    = 4;
  localparam int unsigned REGION_W = 4;
  localparam int unsigned ATOP_W   = 6;
  localparam int unsigned RESP_W   = 2;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R} state_e;

  localparam logic [2:0]        AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]        AXI_BURST_INCR  = 2'b01;
  localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // TCDM request captured at grant
  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic              wen;
  } tcdm_req_t;

  function automatic logic is_err(input logic [RESP_W-1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/tcdm2axi_bridge.sv
// Converts each TCDM access into one single-beat AXI4 transaction, one outstanding.
// Optional TCDM2AXI_RESP_ERR_EN reports SLVERR/DECERR on r_opc.
module tcdm2axi_bridge
  import tcdm2axi_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_USER_WIDTH = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // TCDM slave port
  input  logic                      tcdm_req,
  output logic                      tcdm_gnt_c,
  input  logic [ADDR_W-1:0]         tcdm_add,
  input  logic                      tcdm_wen,
  input  logic [DATA_W-1:0]         tcdm_wdata,
  input  logic [BE_W-1:0]           tcdm_be,
  output logic                      tcdm_r_valid,
  output logic [DATA_W-1:0]         tcdm_r_rdata,
  output logic                      tcdm_r_opc,
  // AXI write address
  output logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  output logic [ADDR_W-1:0]         axi_aw_addr,
  output logic [LEN_W-1:0]          axi_aw_len,
  output logic [2:0]                axi_aw_size,
  output logic [1:0]                axi_aw_burst,
  output logic                      axi_aw_lock,
  output logic [CACHE_W-1:0]        axi_aw_cache,
  output logic [PROT_W-1:0]         axi_aw_prot,
  output logic [QOS_W-1:0]          axi_aw_qos,
  output logic [REGION_W-1:0]       axi_aw_region,
  output logic [ATOP_W-1:0]         axi_aw_atop,
  output logic [AXI_USER_WIDTH-1:0] axi_aw_user,
  output logic                      axi_aw_valid,
  input  logic                      axi_aw_ready,
  // AXI write data
  output logic [DATA_W-1:0]         axi_w_data,
  output logic [BE_W-1:0]           axi_w_strb,
  output logic                      axi_w_last,
  output logic [AXI_USER_WIDTH-1:0] axi_w_user,
  output logic                      axi_w_valid,
  input  logic                      axi_w_ready,
  // AXI write response
  input  logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  input  logic [RESP_W-1:0]         axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0] axi_b_user,
  input  logic                      axi_b_valid,
  output logic                      axi_b_ready,
  // AXI read address
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  output logic [ADDR_W-1:0]         axi_ar_addr,
  output logic [LEN_W-1:0]          axi_ar_len,
  output logic [2:0]                axi_ar_size,
  output logic [1:0]                axi_ar_burst,
  output logic                      axi_ar_lock,
  output logic [CACHE_W-1:0]        axi_ar_cache,
  output logic [PROT_W-1:0]         axi_ar_prot,
  output logic [QOS_W-1:0]          axi_ar_qos,
  output logic [REGION_W-1:0]       axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0] axi_ar_user,
  output logic                      axi_ar_valid,
  input  logic                      axi_ar_ready,
  // AXI read data
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  input  logic [DATA_W-1:0]         axi_r_data,
  input  logic [RESP_W-1:0]         axi_r_resp,
  input  logic                      axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0] axi_r_user,
  input  logic                      axi_r_valid,
  output logic                      axi_r_ready
);

  state_e    state_q, state_d;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      aw_valid_d, w_valid_d, ar_valid_d, b_ready_d, r_ready_d, r_valid_d;
  logic      capture, rdata_load;
  logic      aw_hs, w_hs, ar_hs, b_hs, r_hs;
  tcdm_req_t req_q;

  assign aw_hs = axi_aw_valid & axi_aw_ready;
  assign w_hs  = axi_w_valid  & axi_w_ready;
  assign ar_hs = axi_ar_valid & axi_ar_ready;
  assign b_hs  = axi_b_valid  & axi_b_ready;
  assign r_hs  = axi_r_valid  & axi_r_ready;

  assign tcdm_gnt_c = tcdm_req && (state_q == IDLE);

  // Fixed single-beat, 4-byte INCR attributes
  assign axi_aw_id     = '0;
  assign axi_aw_addr   = req_q.add;
  assign axi_aw_len    = '0;
  assign axi_aw_size   = AXI_SIZE_4B;
  assign axi_aw_burst  = AXI_BURST_INCR;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = '0;
  assign axi_aw_prot   = '0;
  assign axi_aw_qos    = '0;
  assign axi_aw_region = '0;
  assign axi_aw_atop   = '0;
  assign axi_aw_user   = '0;
  assign axi_w_data    = req_q.wdata;
  assign axi_w_strb    = req_q.be;
  assign axi_w_last    = 1'b1;
  assign axi_w_user    = '0;
  assign axi_ar_id     = '0;
  assign axi_ar_addr   = req_q.add;
  assign axi_ar_len    = '0;
  assign axi_ar_size   = AXI_SIZE_4B;
  assign axi_ar_burst  = AXI_BURST_INCR;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = '0;
  assign axi_ar_prot   = '0;
  assign axi_ar_qos    = '0;
  assign axi_ar_region = '0;
  assign axi_ar_user   = '0;

  // Next state plus next values of the registered valid/ready outputs
  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    aw_valid_d = 1'b0;
    w_valid_d  = 1'b0;
    ar_valid_d = 1'b0;
    b_ready_d  = 1'b0;
    r_ready_d  = 1'b0;
    r_valid_d  = 1'b0;
    capture    = 1'b0;
    rdata_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (tcdm_gnt_c) begin
          capture = 1'b1;
          if (tcdm_wen) begin
            state_d    = READ;
            ar_valid_d = 1'b1;
          end else begin
            state_d    = WRITE;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = WAIT_B;
          b_ready_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_valid_d = !aw_done_d;
          w_valid_d  = !w_done_d;
        end
      end
      WAIT_B: begin
        if (b_hs) begin
          state_d   = IDLE;
          r_valid_d = 1'b1;
        end else begin
          b_ready_d = 1'b1;
        end
      end
      READ: begin
        if (ar_hs) begin
          state_d   = WAIT_R;
          r_ready_d = 1'b1;
        end else begin
          ar_valid_d = 1'b1;
        end
      end
      WAIT_R: begin
        if (r_hs) begin
          state_d    = IDLE;
          r_valid_d  = 1'b1;
          rdata_load = 1'b1;
        end else begin
          r_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      axi_aw_valid <= 1'b0;
      axi_w_valid  <= 1'b0;
      axi_ar_valid <= 1'b0;
      axi_b_ready  <= 1'b0;
      axi_r_ready  <= 1'b0;
      tcdm_r_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      axi_aw_valid <= aw_valid_d;
      axi_w_valid  <= w_valid_d;
      axi_ar_valid <= ar_valid_d;
      axi_b_ready  <= b_ready_d;
      axi_r_ready  <= r_ready_d;
      tcdm_r_valid <= r_valid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (capture) begin
      req_q <= '{add: tcdm_add, wdata: tcdm_wdata, be: tcdm_be, wen: tcdm_wen};
    end
  end

  // Read data holds across writes; only an R handshake updates it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcdm_r_rdata <= '0;
    end else if (rdata_load) begin
      tcdm_r_rdata <= axi_r_data;
    end
  end

`ifdef TCDM2AXI_RESP_ERR_EN
  logic r_opc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opc_q <= 1'b0;
    end else begin
      r_opc_q <= (b_hs && is_err(axi_b_resp)) || (r_hs && is_err(axi_r_resp));
    end
  end

  assign tcdm_r_opc = r_opc_q;

  logic unused_in;
  assign unused_in = ^{axi_b_id, axi_b_user, axi_r_id, axi_r_last, axi_r_user, req_q.wen};
`else
  assign tcdm_r_opc = 1'b0;

  logic unused_in;
  assign unused_in = ^{axi_b_id, axi_b_user, axi_r_id, axi_r_last, axi_r_user, req_q.wen,
                       axi_b_resp, axi_r_resp};
`endif

endmodule

// File: tb/tb_tcdm2axi_bridge.sv
// Bench for tcdm2axi_bridge: directed and random accesses against a cycle-stepped AXI slave.
module tb_tcdm2axi_bridge;

  localparam int unsigned ID_W   = 1;
  localparam int unsigned USER_W = 6;
  localparam logic [35:0] FLD_EXP = {8'h00, 3'b010, 2'b01, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0,
                                     6'h00, 1'b1};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic              tcdm_req, tcdm_gnt_c, tcdm_wen, tcdm_r_valid, tcdm_r_opc;
  logic [31:0]       tcdm_add, tcdm_wdata, tcdm_r_rdata;
  logic [3:0]        tcdm_be;
  logic [ID_W-1:0]   aw_id, ar_id, b_id, r_id;
  logic [31:0]       aw_addr, ar_addr, w_data, r_data;
  logic [7:0]        aw_len, ar_len;
  logic [2:0]        aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]        aw_burst, ar_burst, b_resp, r_resp;
  logic              aw_lock, ar_lock, w_last, r_last;
  logic [3:0]        aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region, w_strb;
  logic [5:0]        aw_atop;
  logic [USER_W-1:0] aw_user, w_user, ar_user, b_user, r_user;
  logic              aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic              ar_valid, ar_ready, r_valid, r_ready;

  tcdm2axi_bridge #(.AXI_ID_WIDTH(ID_W), .AXI_USER_WIDTH(USER_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .tcdm_req(tcdm_req), .tcdm_gnt_c(tcdm_gnt_c), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
    .tcdm_wdata(tcdm_wdata), .tcdm_be(tcdm_be), .tcdm_r_valid(tcdm_r_valid),
    .tcdm_r_rdata(tcdm_r_rdata), .tcdm_r_opc(tcdm_r_opc),
    .axi_aw_id(aw_id), .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_size(aw_size),
    .axi_aw_burst(aw_burst), .axi_aw_lock(aw_lock), .axi_aw_cache(aw_cache),
    .axi_aw_prot(aw_prot), .axi_aw_qos(aw_qos), .axi_aw_region(aw_region),
    .axi_aw_atop(aw_atop), .axi_aw_user(aw_user), .axi_aw_valid(aw_valid),
    .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_strb(w_strb), .axi_w_last(w_last), .axi_w_user(w_user),
    .axi_w_valid(w_valid), .axi_w_ready(w_ready),
    .axi_b_id(b_id), .axi_b_resp(b_resp), .axi_b_user(b_user), .axi_b_valid(b_valid),
    .axi_b_ready(b_ready),
    .axi_ar_id(ar_id), .axi_ar_addr(ar_addr), .axi_ar_len(ar_len), .axi_ar_size(ar_size),
    .axi_ar_burst(ar_burst), .axi_ar_lock(ar_lock), .axi_ar_cache(ar_cache),
    .axi_ar_prot(ar_prot), .axi_ar_qos(ar_qos), .axi_ar_region(ar_region),
    .axi_ar_user(ar_user), .axi_ar_valid(ar_valid), .axi_ar_ready(ar_ready),
    .axi_r_id(r_id), .axi_r_data(r_data), .axi_r_resp(r_resp), .axi_r_last(r_last),
    .axi_r_user(r_user), .axi_r_valid(r_valid), .axi_r_ready(r_ready)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] model_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Error reporting exists only in the macro build
  function automatic logic exp_opc(input logic [1:0] resp);
`ifdef TCDM2AXI_RESP_ERR_EN
    return (resp == 2'b10) || (resp == 2'b11);
`else
    return 1'b0;
`endif
  endfunction

  task automatic slave_idle();
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = 2'b00; b_id = '0; b_user = '0;
    r_valid = 1'b0; r_resp = 2'b00; r_id = '0; r_user = '0; r_last = 1'b0; r_data = '0;
  endtask

  // One access: optional grant wait, then a per-cycle slave with programmable delays
  task automatic run_txn(input string tag, input bit is_read, input logic [31:0] add,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly,
                         input logic [31:0] sdata, input logic [1:0] resp,
                         input bit spur, input bit hold, input bit pre);
    int rv_cnt = 0, rv_k = -1, aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, exp_lat;
    bit aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    bit proto_bad = 0, pay_bad = 0, gnt_bad = 0, gnt_ok = 0, gnt_seen = 0;
    logic [31:0] got_rdata = '0, cap_addr = '0, cap_wdata = '0, exp_rdata;
    logic [3:0]  cap_strb = '0;
    logic        got_opc = 1'b0;
    logic [35:0] cap_fld = '0;
    logic [12:0] cap_idu = '0;
    logic [4:0]  exp_vec;
    if (!pre) begin
      tcdm_req = 1'b1; tcdm_wen = is_read; tcdm_add = add; tcdm_wdata = wdata; tcdm_be = be;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (tcdm_gnt_c) begin gnt_seen = 1; break; end
        @(negedge clk);
      end
      check({tag, "_gnt"}, 64'(gnt_seen), 64'(1));
    end
    @(posedge clk);
    #1;
    if (!hold) tcdm_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (tcdm_r_valid) begin
        rv_cnt++;
        if (rv_k < 0) rv_k = k;
        got_rdata = tcdm_r_rdata;
        got_opc   = tcdm_r_opc;
      end
      if (hold) begin
        if (tcdm_r_valid) gnt_ok = tcdm_gnt_c;
        else if (tcdm_gnt_c) gnt_bad = 1;
      end
      if (is_read) exp_vec = {1'b0, 1'b0, !ar_hs, 1'b0, ar_hs && !r_hs};
      else         exp_vec = {!aw_hs, !w_hs, 1'b0, aw_hs && w_hs && !b_hs, 1'b0};
      if ({aw_valid, w_valid, ar_valid, b_ready, r_ready} !== exp_vec) proto_bad = 1;
      if (aw_valid && (aw_addr !== add)) pay_bad = 1;
      if (w_valid && ((w_data !== wdata) || (w_strb !== be))) pay_bad = 1;
      if (ar_valid && (ar_addr !== add)) pay_bad = 1;
      slave_idle();
      b_valid = spur && is_read;
      b_resp  = 2'b10;
      r_valid = spur && !is_read;
      r_data  = $urandom;
      r_resp  = 2'b11;
      if (!is_read) begin
        if (aw_hs && w_hs && !b_hs) begin
          if (b_n >= b_dly) begin
            b_valid = 1'b1; b_resp = resp; b_hs = b_ready;
          end
          b_n++;
        end
        if (!aw_hs) begin
          if (aw_n >= aw_dly) begin
            aw_ready = 1'b1; aw_hs = aw_valid;
            cap_addr = aw_addr;
            cap_fld = {aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
                       aw_region, aw_atop, w_last};
            cap_idu = {aw_id, aw_user, w_user};
          end
          aw_n++;
        end
        if (!w_hs) begin
          if (w_n >= w_dly) begin
            w_ready = 1'b1; w_hs = w_valid;
            cap_wdata = w_data; cap_strb = w_strb;
          end
          w_n++;
        end
      end else begin
        if (ar_hs && !r_hs) begin
          if (r_n >= r_dly) begin
            r_valid = 1'b1; r_data = sdata; r_resp = resp; r_last = 1'b1; r_hs = r_ready;
          end
          r_n++;
        end
        if (!ar_hs) begin
          if (ar_n >= ar_dly) begin
            ar_ready = 1'b1; ar_hs = ar_valid;
            cap_addr = ar_addr;
            cap_fld = {ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
                       ar_region, 6'h00, 1'b1};
            cap_idu = {ar_id, ar_user, 6'h00};
          end
          ar_n++;
        end
      end
      if ((rv_k > 0) && (hold || (k > rv_k))) break;
    end
    slave_idle();
    exp_lat   = is_read ? (3 + ar_dly + r_dly) : (3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly);
    exp_rdata = is_read ? sdata : model_rdata;
    check({tag, "_rv_count"}, 64'(rv_cnt), 64'(1));
    check({tag, "_latency"}, 64'(rv_k), 64'(exp_lat));
    check({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
    check({tag, "_opc"}, 64'(got_opc), 64'(exp_opc(resp)));
    check({tag, "_addr"}, 64'(cap_addr), 64'(add));
    check({tag, "_attrs"}, 64'(cap_fld), 64'(FLD_EXP));
    check({tag, "_id_user"}, 64'(cap_idu), 64'(0));
    check({tag, "_protocol"}, 64'(proto_bad), 64'(0));
    check({tag, "_payload"}, 64'(pay_bad), 64'(0));
    if (!is_read) check({tag, "_wbeat"}, 64'({cap_strb, cap_wdata}), 64'({be, wdata}));
    if (hold) begin
      check({tag, "_gnt_in_flight"}, 64'(gnt_bad), 64'(0));
      check({tag, "_gnt_b2b"}, 64'(gnt_ok), 64'(1));
    end
    model_rdata = exp_rdata;
  endtask

  initial begin
    bit gnt_seen;
    tcdm_req = 1'b0; tcdm_wen = 1'b0; tcdm_add = '0; tcdm_wdata = '0; tcdm_be = '0;
    slave_idle();
    model_rdata = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, tcdm_r_valid,
                                tcdm_r_opc}), 64'(0));
    check("reset_rdata", 64'(tcdm_r_rdata), 64'(0));
    check("reset_addr", 64'({aw_addr, w_data}), 64'(0));
    rst_ni = 1'b1;
    @(negedge clk);

    run_txn("rd_ready", 1, 32'h1A10_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0,
            32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    run_txn("wr_skew", 0, 32'h1000_0010, 32'h1234_5678, 4'b0011, 3, 0, 0, 0, 0,
            32'h0, 2'b00, 1, 0, 0);
    run_txn("wr_wlate", 0, 32'h0000_0003, 32'hCAFE_F00D, 4'b1000, 0, 2, 2, 0, 0,
            32'h0, 2'b00, 0, 0, 0);
    run_txn("b2b_a", 1, 32'h2000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0,
            32'hA5A5_0001, 2'b00, 0, 1, 0);
    run_txn("b2b_b", 1, 32'h2000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0,
            32'h5A5A_0002, 2'b00, 0, 0, 1);
    run_txn("rd_slverr", 1, 32'h3000_0000, 32'h0, 4'h0, 0, 0, 0, 1, 2,
            32'h0BAD_0001, 2'b10, 1, 0, 0);
    run_txn("wr_decerr", 0, 32'h3000_0004, 32'h7777_8888, 4'hF, 1, 1, 1, 0, 0,
            32'h0, 2'b11, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      bit rd = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", t), rd, $urandom, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0);
    end

    // Abort a read in WAIT_R while the slave presents r_valid
    gnt_seen = 0;
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h4000_0000;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tcdm_gnt_c) begin gnt_seen = 1; break; end
      @(negedge clk);
    end
    check("rst_gnt", 64'(gnt_seen), 64'(1));
    @(posedge clk);
    #1 tcdm_req = 1'b0;
    @(negedge clk);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    check("rst_in_wait_r", 64'(r_ready), 64'(1));
    r_valid = 1'b1; r_data = 32'hBAD0_BAD0; r_resp = 2'b10;
    rst_ni = 1'b0;
    #1;
    check("rst_async_drop", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready, tcdm_r_valid}),
          64'(0));
    @(negedge clk);
    check("rst_no_resp", 64'({tcdm_r_valid, tcdm_r_opc}), 64'(0));
    check("rst_rdata_clear", 64'(tcdm_r_rdata), 64'(0));
    slave_idle();
    @(negedge clk);
    model_rdata = '0;
    tcdm_req = 1'b1; tcdm_wen = 1'b1; tcdm_add = 32'h4000_0040;
    rst_ni = 1'b1;
    #1;
    check("rst_release_gnt", 64'(tcdm_gnt_c), 64'(1));
    run_txn("post_rst", 1, 32'h4000_0040, 32'h0, 4'h0, 0, 0, 0, 0, 0,
            32'h1357_9BDF, 2'b00, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcdm2axi_bridge.md
TCDM2AXI_BRIDGE -- requirements
Module: tcdm2axi_bridge

Interface
REQ-001 AXI_ID_WIDTH, default 1, SHALL set the ID width of axi_mst; every issued ID is all-zero.
REQ-002 AXI_USER_WIDTH, default 6, SHALL set the user width of axi_mst; every issued user field is all-zero.
REQ-003 clk_i  input  1  SHALL be the single clock; all state is on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 tcdm_slv  XBAR_TCDM_BUS.Slave  add 32, wdata 32, be 4, wen 1 (1 = read), rdata 32  SHALL be the TCDM request/response port.
REQ-006 axi_mst  AXI_BUS.Master  addr 32, data 32, id AXI_ID_WIDTH, user AXI_USER_WIDTH  SHALL be the AXI4 initiator port.

Function
REQ-007 SHALL convert each TCDM access into exactly one single-beat AXI4 transaction, with one access outstanding.
REQ-008 FSM states SHALL be IDLE, WRITE, WAIT_B, READ and WAIT_R.
REQ-009 gnt SHALL equal req && state==IDLE (combinational); on grant, add/wdata/be/wen SHALL be registered and the FSM SHALL go to WRITE (wen=0) or READ (wen=1).
REQ-010 Issued fields SHALL be: len 0, size 3'b010, burst INCR, lock/cache/prot/qos/region/atop 0, w_last 1, w_strb = registered be, and ax_addr = registered add, unaligned addresses passed unmodified.
REQ-011 WRITE: aw_valid and w_valid SHALL rise together and each SHALL drop independently after its own handshake, tracked by aw_done/w_done flags.
REQ-012 WRITE: when both handshakes are complete (the same cycle included), the FSM SHALL move to WAIT_B.
REQ-013 WAIT_B: b_ready=1; on b handshake -> IDLE. b_ready SHALL be 0 in every other state.
REQ-014 READ: ar_valid=1 until ar handshake -> WAIT_R. WAIT_R: r_ready=1; on r handshake, r_data SHALL be registered -> IDLE. r_ready SHALL be 0 in every other state.
REQ-015 r_valid SHALL pulse exactly one cycle after the b or r handshake, for both reads and writes.
REQ-016 For writes, r_rdata SHALL hold its previous value.
REQ-017 A new grant SHALL be allowed in the same cycle as r_valid (back-to-back).
REQ-018 With an always-ready slave, minimum latency SHALL be: grant c0, AW/W or AR handshake c1, B or R handshake c2, r_valid c3, next grant c3.
REQ-019 Valid signals SHALL never be withdrawn before their handshake, and payload SHALL be stable while valid is high.
REQ-020 req asserted outside IDLE SHALL receive gnt=0 and SHALL NOT be captured.
REQ-021 Unexpected b_valid or r_valid outside WAIT_B/WAIT_R SHALL be ignored (ready low).

Reset
REQ-022 On rst_ni low, the FSM SHALL go to IDLE and aw_done/w_done SHALL clear, asynchronously.
REQ-023 On rst_ni low, all AXI valid/ready outputs and r_valid SHALL be 0, and r_rdata, r_opc and all captured request registers SHALL be 0.
REQ-024 Reset mid-transaction SHALL abort the transaction silently, without a TCDM response; the system resets the AXI slave together with this block.

Configuration
REQ-025 With TCDM2AXI_RESP_ERR_EN defined, r_opc SHALL be 1 for one r_valid cycle when bresp or rresp is SLVERR or DECERR, and 0 otherwise.
REQ-026 With TCDM2AXI_RESP_ERR_EN undefined, r_opc SHALL be tied to 0, bresp and rresp SHALL be ignored, and no response register SHALL exist.

Structure
REQ-027 tcdm2axi_pkg SHALL hold the FSM state enum, the size constant 3'b010, the INCR burst constant and the SLVERR/DECERR codes.
REQ-028 No sub-module SHALL be used; the FSM, capture registers and response register SHALL live in tcdm2axi_bridge.

Verification
REQ-029 Read, ready slave: req, wen=1, add 0x1A10_0004; slave returns 0xDEAD_BEEF -> ar_addr 0x1A10_0004, size 2, len 0; r_valid at c3 with rdata 0xDEAD_BEEF, r_opc 0.
REQ-030 Write, skewed handshakes: add 0x1000_0010, wdata 0x1234_5678, be 4'b0011; awready delayed 3 cycles, wready immediate -> w_valid drops after c1, aw_valid stays high to c4, b_ready only after both, r_valid exactly once.
REQ-031 Back-to-back: two reads held on req -> second gnt in the same cycle as the first r_valid; second gnt=0 while the first is in flight.
REQ-032 Error response: rresp=SLVERR -> r_opc=1 with the macro defined, r_opc=0 without it; bresp=DECERR gives the same pair of results.
REQ-033 Reset while in WAIT_R with r_valid pending from the slave -> all valids and r_ready drop immediately, no r_valid on TCDM, next req granted in the first cycle after reset release.
